// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared ISA decode constants and FSM state type for the memory stage
package mem_stage_ctrl_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] ins);
        return ins[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/mw_regbank.sv
// rtl/mw_regbank.sv - M/W boundary register bank with common enable and synchronous clear
module mw_regbank #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] nxt_o,
    input  logic [DATA_W-1:0] nxt_d,
    input  logic [DATA_W-1:0] nxt_ins,
    input  logic              nxt_ovf,
    input  logic              nxt_valid,
    output logic [DATA_W-1:0] mw_o,
    output logic [DATA_W-1:0] mw_d,
    output logic [DATA_W-1:0] mw_ins,
    output logic              mw_ovf,
    output logic              mw_valid
);

    always_ff @(posedge clk) begin
        if (clr) begin
            mw_o     <= '0;
            mw_d     <= '0;
            mw_ins   <= '0;
            mw_ovf   <= 1'b0;
            mw_valid <= 1'b0;
        end else if (en) begin
            mw_o     <= nxt_o;
            mw_d     <= nxt_d;
            mw_ins   <= nxt_ins;
            mw_ovf   <= nxt_ovf;
            mw_valid <= nxt_valid;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage: lw/sw over a req/ack data memory, stall control, M/W latch
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] xm_o,
    input  logic [DATA_W-1:0] xm_b,
    input  logic [DATA_W-1:0] xm_ins,
    input  logic              xm_ovf,
    input  logic              xm_valid,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] mw_o,
    output logic [DATA_W-1:0] mw_d,
    output logic [DATA_W-1:0] mw_ins,
    output logic              mw_ovf,
    output logic              mw_valid
);

    state_t            state;
    logic [4:0]        opcode;
    logic              is_lw;
    logic              is_sw;
    logic              memop;
    logic [DATA_W-1:0] nxt_d;

    assign opcode = opcode_of(xm_ins);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign memop  = xm_valid & (is_lw | is_sw);

    // X/M is frozen while stalled, so the held instruction still selects lw vs sw at ack time.
    always_comb begin
        stall = 1'b0;
        nxt_d = '0;
        if (!reset) begin
            if (state == ST_IDLE)
                stall = memop;
            else
                stall = ~dmem_ack;
        end
        if (state == ST_REQ && dmem_ack && is_lw)
            nxt_d = dmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memop) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_sw;
                        dmem_addr  <= xm_o[ADDR_W-1:0];
                        dmem_wdata <= xm_b;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Every stalled cycle pushes a bubble into M/W; only the completing cycle carries valid.
    mw_regbank #(.DATA_W(DATA_W)) u_mw_regbank (
        .clk       (clk),
        .en        (1'b1),
        .clr       (reset),
        .nxt_o     (xm_o),
        .nxt_d     (nxt_d),
        .nxt_ins   (xm_ins),
        .nxt_ovf   (xm_ovf),
        .nxt_valid (xm_valid & ~stall),
        .mw_o      (mw_o),
        .mw_d      (mw_d),
        .mw_ins    (mw_ins),
        .mw_ovf    (mw_ovf),
        .mw_valid  (mw_valid)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - table-driven and sequence checks for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam logic [31:0] LW = 32'h4000_0000;
    localparam logic [31:0] SW = 32'h3800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] xm_o = '0, xm_b = '0, xm_ins = '0;
    logic        xm_ovf = 1'b0, xm_valid = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] mw_o, mw_d, mw_ins;
    logic        mw_ovf, mw_valid;

    int n_applied = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .xm_o       (xm_o),
        .xm_b       (xm_b),
        .xm_ins     (xm_ins),
        .xm_ovf     (xm_ovf),
        .xm_valid   (xm_valid),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mw_o       (mw_o),
        .mw_d       (mw_d),
        .mw_ins     (mw_ins),
        .mw_ovf     (mw_ovf),
        .mw_valid   (mw_valid)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] o;
        logic [31:0] b;
        logic        ovf;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_o;
        logic [31:0] e_d;
        logic [31:0] e_ins;
        logic        e_ovf;
        logic        e_valid;
    } vec_t;

    vec_t vt[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mem_seq(input logic is_lw, input int n, input logic [31:0] addr, input logic [31:0] data);
        int  stalls;
        int  edges;
        bit  done;
        stalls = 0;
        edges  = 0;
        done   = 1'b0;
        @(negedge clk);
        xm_valid = 1'b1; xm_ins = is_lw ? LW : SW; xm_o = addr; xm_b = data; xm_ovf = 1'b1;
        dmem_rdata = data;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            dmem_ack = (k == n + 1);
            #1;
            if (stall) stalls++;
            done = !stall;
            @(posedge clk);
            edges++;
        end
        #1;
        chk($sformatf("seq%0d_stall_cycles", n), stalls, n + 1);
        chk($sformatf("seq%0d_edges", n), edges, n + 2);
        chk($sformatf("seq%0d_mw_valid", n), {31'b0, mw_valid}, 32'h1);
        chk($sformatf("seq%0d_mw_d", n), mw_d, is_lw ? data : 32'h0);
        chk($sformatf("seq%0d_mw_ovf", n), {31'b0, mw_ovf}, 32'h1);
        chk($sformatf("seq%0d_req_low", n), {31'b0, dmem_req}, 32'h0);
        @(negedge clk);
        xm_valid = 1'b0; xm_ins = '0; xm_o = '0; xm_ovf = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("seq%0d_valid_once", n), {31'b0, mw_valid}, 32'h0);
    endtask

    initial begin
        //        rst   vld   ins            o              b              ovf   ack   rdata           stall req   we    addr    wdata          mw_o           mw_d           mw_ins         ovf   valid
        vt[0]  = '{1'b1,1'b0,32'h0,         32'h0,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h000,32'h0,         32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[1]  = '{1'b1,1'b1,LW,            32'h10,        32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h000,32'h0,         32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[2]  = '{1'b0,1'b1,32'h3,         32'h5,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h000,32'h0,         32'h5,         32'h0,         32'h3,         1'b0,1'b1};
        vt[3]  = '{1'b0,1'b1,32'h4,         32'h7,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h000,32'h0,         32'h7,         32'h0,         32'h4,         1'b0,1'b1};
        vt[4]  = '{1'b0,1'b0,LW,            32'h20,        32'h0,         1'b0,1'b1,32'h1234,       1'b0,1'b0,1'b0,12'h000,32'h0,         32'h20,        32'h0,         LW,            1'b0,1'b0};
        vt[5]  = '{1'b0,1'b1,SW,            32'h10,        32'hDEADBEEF,  1'b0,1'b0,32'h0,          1'b1,1'b1,1'b1,12'h010,32'hDEADBEEF,  32'h10,        32'h0,         SW,            1'b0,1'b0};
        vt[6]  = '{1'b0,1'b1,SW,            32'h10,        32'hDEADBEEF,  1'b0,1'b0,32'h0,          1'b1,1'b1,1'b1,12'h010,32'hDEADBEEF,  32'h10,        32'h0,         SW,            1'b0,1'b0};
        vt[7]  = '{1'b0,1'b1,SW,            32'h10,        32'hDEADBEEF,  1'b0,1'b0,32'h0,          1'b1,1'b1,1'b1,12'h010,32'hDEADBEEF,  32'h10,        32'h0,         SW,            1'b0,1'b0};
        vt[8]  = '{1'b0,1'b1,SW,            32'h10,        32'hDEADBEEF,  1'b0,1'b1,32'hCAFEF00D,   1'b0,1'b0,1'b1,12'h010,32'hDEADBEEF,  32'h10,        32'h0,         SW,            1'b0,1'b1};
        vt[9]  = '{1'b0,1'b0,32'h0,         32'h0,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b1,12'h010,32'hDEADBEEF,  32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[10] = '{1'b0,1'b1,LW,            32'h10,        32'h0,         1'b0,1'b0,32'h0,          1'b1,1'b1,1'b0,12'h010,32'h0,         32'h10,        32'h0,         LW,            1'b0,1'b0};
        vt[11] = '{1'b0,1'b1,LW,            32'h10,        32'h0,         1'b0,1'b1,32'hDEADBEEF,   1'b0,1'b0,1'b0,12'h010,32'h0,         32'h10,        32'hDEADBEEF,  LW,            1'b0,1'b1};
        vt[12] = '{1'b0,1'b0,32'h0,         32'h0,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h010,32'h0,         32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[13] = '{1'b0,1'b1,LW,            32'hFFFFF123,  32'h0,         1'b0,1'b0,32'h0,          1'b1,1'b1,1'b0,12'h123,32'h0,         32'hFFFFF123,  32'h0,         LW,            1'b0,1'b0};
        vt[14] = '{1'b0,1'b1,LW,            32'hFFFFF123,  32'h0,         1'b0,1'b0,32'h0,          1'b1,1'b1,1'b0,12'h123,32'h0,         32'hFFFFF123,  32'h0,         LW,            1'b0,1'b0};
        vt[15] = '{1'b1,1'b1,LW,            32'hFFFFF123,  32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h000,32'h0,         32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[16] = '{1'b0,1'b0,32'h0,         32'h0,         32'h0,         1'b0,1'b1,32'h5555,       1'b0,1'b0,1'b0,12'h000,32'h0,         32'h0,         32'h0,         32'h0,         1'b0,1'b0};
        vt[17] = '{1'b0,1'b1,LW,            32'h8,         32'h11,        1'b0,1'b0,32'h0,          1'b1,1'b1,1'b0,12'h008,32'h11,        32'h8,         32'h0,         LW,            1'b0,1'b0};
        vt[18] = '{1'b0,1'b1,LW,            32'h8,         32'h11,        1'b0,1'b1,32'hA5A5A5A5,   1'b0,1'b0,1'b0,12'h008,32'h11,        32'h8,         32'hA5A5A5A5,  LW,            1'b0,1'b1};
        vt[19] = '{1'b0,1'b1,32'h5,         32'h7FFFFFFF,  32'h0,         1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,12'h008,32'h11,        32'h7FFFFFFF,  32'h0,         32'h5,         1'b1,1'b1};
        vt[20] = '{1'b0,1'b1,SW,            32'h9,         32'h22,        1'b0,1'b0,32'h0,          1'b1,1'b1,1'b1,12'h009,32'h22,        32'h9,         32'h0,         SW,            1'b0,1'b0};
        vt[21] = '{1'b0,1'b1,SW,            32'h9,         32'h22,        1'b0,1'b1,32'h77,         1'b0,1'b0,1'b1,12'h009,32'h22,        32'h9,         32'h0,         SW,            1'b0,1'b1};
        vt[22] = '{1'b0,1'b0,32'h0,         32'h0,         32'h0,         1'b0,1'b0,32'h0,          1'b0,1'b0,1'b1,12'h009,32'h22,        32'h0,         32'h0,         32'h0,         1'b0,1'b0};

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            reset = vt[i].rst; xm_valid = vt[i].valid; xm_ins = vt[i].ins; xm_o = vt[i].o;
            xm_b = vt[i].b; xm_ovf = vt[i].ovf; dmem_ack = vt[i].ack; dmem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_dmem_req", i), {31'b0, dmem_req}, {31'b0, vt[i].e_req});
            chk($sformatf("v%0d_dmem_we", i), {31'b0, dmem_we}, {31'b0, vt[i].e_we});
            chk($sformatf("v%0d_dmem_addr", i), {20'b0, dmem_addr}, {20'b0, vt[i].e_addr});
            chk($sformatf("v%0d_dmem_wdata", i), dmem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_mw_o", i), mw_o, vt[i].e_o);
            chk($sformatf("v%0d_mw_d", i), mw_d, vt[i].e_d);
            chk($sformatf("v%0d_mw_ins", i), mw_ins, vt[i].e_ins);
            chk($sformatf("v%0d_mw_ovf", i), {31'b0, mw_ovf}, {31'b0, vt[i].e_ovf});
            chk($sformatf("v%0d_mw_valid", i), {31'b0, mw_valid}, {31'b0, vt[i].e_valid});
        end

        mem_seq(1'b0, 2, 32'h0000_0010, 32'hDEADBEEF);
        mem_seq(1'b1, 0, 32'h0000_0010, 32'hDEADBEEF);
        mem_seq(1'b1, 4, 32'h0000_0ABC, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
